// File: rtl/lem_pkg.sv
// Shared types and defaults for the lemming walker family.
package lem_pkg;

    localparam int SPLAT_CYCLES_DEF = 20;

    typedef enum logic [2:0] {
        WALK_L,
        WALK_R,
        FALL_L,
        FALL_R,
        DIG_L,
        DIG_R,
        SPLAT
    } state_t;

endpackage

// File: rtl/lem_fall_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module lem_fall_counter #(
    parameter int MAX = 20,
    parameter int W   = $clog2(MAX+1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         sat_reached
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign sat_reached = (cnt >= MAX_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !sat_reached)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/lemming_walker_splat.sv
// Walker/faller/digger lemming FSM with a fall-length limit that ends in SPLAT.
module lemming_walker_splat
    import lem_pkg::*;
#(
    parameter int SPLAT_CYCLES = SPLAT_CYCLES_DEF,
    parameter int CNT_W        = $clog2(SPLAT_CYCLES+1)
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             bump_left,
    input  logic             bump_right,
    input  logic             ground,
    input  logic             dig,
    output logic             walk_left,
    output logic             walk_right,
    output logic             aaah,
    output logic             digging,
    output logic             splat,
    output logic [CNT_W-1:0] fall_cnt
);

    state_t state, state_nxt;
    logic   falling, falling_nxt, sat_reached;

    assign falling     = (state == FALL_L) || (state == FALL_R);
    assign falling_nxt = (state_nxt == FALL_L) || (state_nxt == FALL_R);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n)
            state <= WALK_L;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WALK_L: begin
                if (!ground)        state_nxt = FALL_L;
                else if (dig)       state_nxt = DIG_L;
                else if (bump_left) state_nxt = WALK_R;
            end
            WALK_R: begin
                if (!ground)         state_nxt = FALL_R;
                else if (dig)        state_nxt = DIG_R;
                else if (bump_right) state_nxt = WALK_L;
            end
            DIG_L:  if (!ground) state_nxt = FALL_L;
            DIG_R:  if (!ground) state_nxt = FALL_R;
            // Landing after a fall that reached the limit is fatal.
            FALL_L: if (ground) state_nxt = sat_reached ? SPLAT : WALK_L;
            FALL_R: if (ground) state_nxt = sat_reached ? SPLAT : WALK_R;
            SPLAT:  state_nxt = SPLAT;
            default: state_nxt = WALK_L;
        endcase
    end

    // Clearing on the next state keeps fall_cnt at 0 in every non-fall cycle,
    // including the first cycle after landing.
    lem_fall_counter #(
        .MAX (SPLAT_CYCLES),
        .W   (CNT_W)
    ) u_fall_cnt (
        .clk         (clk),
        .rst_n       (areset_n),
        .clr         (!falling_nxt),
        .en          (falling && !ground),
        .cnt         (fall_cnt),
        .sat_reached (sat_reached)
    );

    assign walk_left  = (state == WALK_L);
    assign walk_right = (state == WALK_R);
    assign aaah       = falling;
    assign digging    = (state == DIG_L) || (state == DIG_R);
    assign splat      = (state == SPLAT);

endmodule

// File: tb/tb_lemming_walker_splat.sv
// Scoreboard bench for lemming_walker_splat at SPLAT_CYCLES=20 and SPLAT_CYCLES=4.
module tb_lemming_walker_splat;

    localparam logic [4:0] F_WL = 5'b10000;
    localparam logic [4:0] F_WR = 5'b01000;
    localparam logic [4:0] F_FA = 5'b00100;
    localparam logic [4:0] F_DG = 5'b00010;
    localparam logic [4:0] F_SP = 5'b00001;

    logic clk, rst20, rst4, bl, br, g, d;
    logic wl20, wr20, aa20, dg20, sp20;
    logic wl4, wr4, aa4, dg4, sp4;
    logic [4:0] cnt20;
    logic [2:0] cnt4;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string      nm;
        logic       bl, br, g, d;
        logic [4:0] f;
        int         cnt;
    } step_t;

    step_t sb[$];

    lemming_walker_splat #(.SPLAT_CYCLES(20)) dut20 (
        .clk(clk), .areset_n(rst20), .bump_left(bl), .bump_right(br),
        .ground(g), .dig(d), .walk_left(wl20), .walk_right(wr20),
        .aaah(aa20), .digging(dg20), .splat(sp20), .fall_cnt(cnt20)
    );

    lemming_walker_splat #(.SPLAT_CYCLES(4)) dut4 (
        .clk(clk), .areset_n(rst4), .bump_left(bl), .bump_right(br),
        .ground(g), .dig(d), .walk_left(wl4), .walk_right(wr4),
        .aaah(aa4), .digging(dg4), .splat(sp4), .fall_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string nm, input logic bl_i, input logic br_i,
                        input logic g_i, input logic d_i, input logic [4:0] f, input int cnt);
        step_t s;
        s.nm = nm; s.bl = bl_i; s.br = br_i; s.g = g_i; s.d = d_i; s.f = f; s.cnt = cnt;
        sb.push_back(s);
    endtask

    function automatic void sample(input bit sel4, output logic [4:0] f, output logic [7:0] c);
        if (sel4) begin
            f = {wl4, wr4, aa4, dg4, sp4};
            c = 8'(cnt4);
        end else begin
            f = {wl20, wr20, aa20, dg20, sp20};
            c = 8'(cnt20);
        end
    endfunction

    // Holds the idle DUT in reset; the DUT under test leaves reset in WALK_L.
    task automatic do_reset(input bit sel4);
        @(negedge clk);
        rst20 = 1'b0; rst4 = 1'b0;
        bl = 1'b0; br = 1'b0; g = 1'b1; d = 1'b0;
        #2;
        if (sel4) rst4 = 1'b1; else rst20 = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] f; logic [7:0] c; step_t e;
        rst20 = 1'b0; rst4 = 1'b0; bl = 1'b0; br = 1'b0; g = 1'b1; d = 1'b0;
        #2;
        sample(1'b0, f, c); total++;
        if (f !== F_WL || c !== 8'd0) $display("FAIL reset_init: flags=%b cnt=%0d, expected flags=%b cnt=0", f, c, F_WL);
        else passed++;
        @(negedge clk); rst20 = 1'b1;
        push("to_walk_r", 1, 0, 1, 0, F_WR, 0);
        push("stay_r",    0, 0, 1, 0, F_WR, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); bl = e.bl; br = e.br; g = e.g; d = e.d;
            @(posedge clk); #1;
            sample(1'b0, f, c); total++;
            if (f !== e.f || c !== 8'(e.cnt)) $display("FAIL %s: flags=%b cnt=%0d, expected flags=%b cnt=%0d", e.nm, f, c, e.f, e.cnt);
            else passed++;
        end
        // 7 ns pulse entirely between two rising edges.
        bl = 1'b0; rst20 = 1'b0;
        #1;
        sample(1'b0, f, c); total++;
        if (f !== F_WL || c !== 8'd0) $display("FAIL reset_async: flags=%b cnt=%0d, expected flags=%b cnt=0", f, c, F_WL);
        else passed++;
        #6 rst20 = 1'b1;
        push("bump_l_after_rst", 1, 0, 1, 0, F_WR, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); bl = e.bl; br = e.br; g = e.g; d = e.d;
            @(posedge clk); #1;
            sample(1'b0, f, c); total++;
            if (f !== e.f || c !== 8'(e.cnt)) $display("FAIL %s: flags=%b cnt=%0d, expected flags=%b cnt=%0d", e.nm, f, c, e.f, e.cnt);
            else passed++;
        end
    endtask

    task automatic test_walk_dig();
        logic [4:0] f; logic [7:0] c; step_t e;
        do_reset(1'b0);
        push("wl_far_bump",   0, 1, 1, 0, F_WL, 0);
        push("wl_both_bumps", 1, 1, 1, 0, F_WR, 0);
        push("wr_far_bump",   1, 0, 1, 0, F_WR, 0);
        push("wr_dig",        0, 0, 1, 1, F_DG, 0);
        push("dig_bumps",     1, 1, 1, 0, F_DG, 0);
        push("dig_dig",       0, 0, 1, 1, F_DG, 0);
        push("dig_fall",      0, 0, 0, 0, F_FA, 0);
        push("fall_r_1",      1, 1, 0, 1, F_FA, 1);
        push("fall_r_2",      0, 0, 0, 0, F_FA, 2);
        push("land_r",        0, 0, 1, 0, F_WR, 0);
        push("wr_bump_r",     0, 1, 1, 0, F_WL, 0);
        push("wl_fall_over_dig", 1, 0, 0, 1, F_FA, 0);
        push("land_l",        0, 0, 1, 0, F_WL, 0);
        push("wl_dig_over_bump", 1, 0, 1, 1, F_DG, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); bl = e.bl; br = e.br; g = e.g; d = e.d;
            @(posedge clk); #1;
            sample(1'b0, f, c); total++;
            if (f !== e.f || c !== 8'(e.cnt)) $display("FAIL %s: flags=%b cnt=%0d, expected flags=%b cnt=%0d", e.nm, f, c, e.f, e.cnt);
            else passed++;
        end
    endtask

    // k = n aaah cycles lands safely; k = n+1 splats and SPLAT then ignores inputs.
    task automatic test_fall_limit(input bit sel4, input int n);
        logic [4:0] f; logic [7:0] c; step_t e;
        do_reset(sel4);
        for (int i = 1; i <= n; i++) push("fall_safe", 0, 0, 0, 0, F_FA, i-1);
        push("land_safe", 0, 0, 1, 0, F_WL, 0);
        for (int i = 1; i <= n+1; i++) push("fall_fatal", 0, 0, 0, 0, F_FA, i-1);
        push("land_splat", 0, 0, 1, 0, F_SP, 0);
        for (int i = 0; i < 10; i++)
            push("splat_hold", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), F_SP, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); bl = e.bl; br = e.br; g = e.g; d = e.d;
            @(posedge clk); #1;
            sample(sel4, f, c); total++;
            if (f !== e.f || c !== 8'(e.cnt)) $display("FAIL %s(n=%0d): flags=%b cnt=%0d, expected flags=%b cnt=%0d", e.nm, n, f, c, e.f, e.cnt);
            else passed++;
        end
    endtask

    task automatic test_long_fall();
        logic [4:0] f; logic [7:0] c; step_t e;
        do_reset(1'b0);
        for (int i = 1; i <= 300; i++) push("long_fall", 0, 0, 0, 0, F_FA, (i-1 < 20) ? i-1 : 20);
        push("long_land", 0, 0, 1, 0, F_SP, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); bl = e.bl; br = e.br; g = e.g; d = e.d;
            @(posedge clk); #1;
            sample(1'b0, f, c); total++;
            if (f !== e.f || c !== 8'(e.cnt)) $display("FAIL %s: flags=%b cnt=%0d, expected flags=%b cnt=%0d", e.nm, f, c, e.f, e.cnt);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] f; logic [7:0] c; step_t e;
        do_reset(1'b0);
        for (int i = 1; i <= 10; i++) push("pre_rst_fall", 0, 0, 0, 0, F_FA, i-1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); bl = e.bl; br = e.br; g = e.g; d = e.d;
            @(posedge clk); #1;
            sample(1'b0, f, c); total++;
            if (f !== e.f || c !== 8'(e.cnt)) $display("FAIL %s: flags=%b cnt=%0d, expected flags=%b cnt=%0d", e.nm, f, c, e.f, e.cnt);
            else passed++;
        end
        rst20 = 1'b0;
        #1;
        sample(1'b0, f, c); total++;
        if (f !== F_WL || c !== 8'd0) $display("FAIL rst_mid_fall: flags=%b cnt=%0d, expected flags=%b cnt=0", f, c, F_WL);
        else passed++;
        g = 1'b1;
        #6 rst20 = 1'b1;
        push("post_rst_walk", 0, 0, 1, 0, F_WL, 0);
        for (int i = 1; i <= 21; i++) push("fall_to_splat", 0, 0, 0, 0, F_FA, i-1);
        push("splat", 0, 0, 1, 0, F_SP, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); bl = e.bl; br = e.br; g = e.g; d = e.d;
            @(posedge clk); #1;
            sample(1'b0, f, c); total++;
            if (f !== e.f || c !== 8'(e.cnt)) $display("FAIL %s: flags=%b cnt=%0d, expected flags=%b cnt=%0d", e.nm, f, c, e.f, e.cnt);
            else passed++;
        end
        rst20 = 1'b0;
        #1;
        sample(1'b0, f, c); total++;
        if (f !== F_WL || c !== 8'd0) $display("FAIL rst_from_splat: flags=%b cnt=%0d, expected flags=%b cnt=0", f, c, F_WL);
        else passed++;
        #6 rst20 = 1'b1;
        push("revived_bump_l", 1, 0, 1, 0, F_WR, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); bl = e.bl; br = e.br; g = e.g; d = e.d;
            @(posedge clk); #1;
            sample(1'b0, f, c); total++;
            if (f !== e.f || c !== 8'(e.cnt)) $display("FAIL %s: flags=%b cnt=%0d, expected flags=%b cnt=%0d", e.nm, f, c, e.f, e.cnt);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_walk_dig();
        test_fall_limit(1'b0, 20);
        test_long_fall();
        test_async_reset();
        test_fall_limit(1'b1, 4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lemming_walker_splat.md
Name: lemming_walker_splat

Overview:
- Parametrised successor to the two-direction walker/faller FSM in the lemmings series.
- Adds digging, a configurable fall-length limit that ends in a terminal SPLAT state, and a saturating fall-cycle counter.
- Sits at the top of the lem3/lem4 exercise tree and is driven directly by the bench.
- All outputs are Moore outputs, decoded from the state register only.

Parameters:
SPLAT_CYCLES, 20, lemming splatters if aaah was high for more than this many cycles before ground returns (legal range 1..255)
CNT_W, $clog2(SPLAT_CYCLES+1), width of the fall counter (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
areset_n  input  1  asynchronous active-low reset
bump_left  input  1  obstacle on left
bump_right  input  1  obstacle on right
ground  input  1  1 = ground under lemming
dig  input  1  request to start digging
walk_left  output  1  state is WALK_L
walk_right  output  1  state is WALK_R
aaah  output  1  state is FALL_L or FALL_R
digging  output  1  state is DIG_L or DIG_R
splat  output  1  state is SPLAT (dead)
fall_cnt  output  CNT_W  current saturating fall count (debug/verification)

Behaviour:
- Reset: areset_n=0 forces WALK_L and fall_cnt=0 immediately, without waiting for a clock edge. Resulting outputs: walk_left=1, all other flags 0. Reset is honoured from any state, including SPLAT and mid-fall.
- States: WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT. Exactly one output flag is high in every state.
- Priority in WALK_x, evaluated at each rising edge:
  - ground=0 -> FALL_x.
  - else dig=1 -> DIG_x.
  - else bump on the wall being walked toward -> opposite WALK. WALK_L uses bump_left; WALK_R uses bump_right.
  - else stay.
  - A bump on the far side is ignored. Simultaneous bumps while walking left -> WALK_R.
- DIG_x:
  - ground=0 -> FALL_x.
  - else stay. bump and dig are ignored.
- FALL_x:
  - ground=0 -> stay; fall_cnt <= min(fall_cnt+1, SPLAT_CYCLES).
  - ground=1 and fall_cnt >= SPLAT_CYCLES -> SPLAT.
  - ground=1 otherwise -> WALK_x, same direction as before the fall.
  - bump and dig are ignored while falling.
- fall_cnt:
  - Cleared to 0 in every non-FALL state.
  - Equals k-1 at the edge where ground=1 is sampled after aaah has been high for k cycles. Splat therefore occurs iff k > SPLAT_CYCLES.
  - Saturates at SPLAT_CYCLES; it never wraps.
- SPLAT: absorbing state. Leaves only via areset_n=0; all inputs are ignored.
- Latency: one clock from input sample to output change. No combinational input-to-output paths.

Decomposition:
- Shared package lem_pkg holds:
  - the state enum, state_t: WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT;
  - the default SPLAT_CYCLES constant.
- One sub-module is natural: lem_fall_counter, a saturating counter with clear/enable inputs and a sat_reached output. The FSM instantiates it.

Test Plan:
- areset_n pulsed low 7 ns between edges, ground=1 -> walk_left=1 before the next edge, fall_cnt=0. Then bump_left=1 for one cycle -> walk_right=1 one edge later.
- WALK_R, dig=1 for one cycle -> digging=1. Then bump_left=bump_right=1 -> digging stays 1. Then ground=0 -> aaah=1. Then ground=1 after 3 aaah cycles -> walk_right=1, splat=0.
- SPLAT_CYCLES=20, ground=0 for exactly 20 aaah cycles then ground=1 -> walk_left=1, splat=0.
- Same setup, 21 aaah cycles -> splat=1 with all other flags 0. Toggle ground, dig and bumps for 10 cycles -> splat stays 1.
- Fall for 300 cycles with SPLAT_CYCLES=20 -> fall_cnt holds 20 with no wrap. Landing -> splat=1.
- Mid-fall at cycle 10, assert areset_n=0 -> walk_left=1 and aaah=0 asynchronously. Repeat from SPLAT -> recovers to walk_left=1.
- Rerun the splat scenarios with SPLAT_CYCLES=4 (CNT_W=3): 4 aaah cycles -> walk, 5 aaah cycles -> splat.
